// File: rtl/twiddle_addr_gen_if.sv
// twiddle_addr_gen_if: sample handshake and twiddle address bus
interface twiddle_addr_gen_if #(parameter int ADDR_W = 6);
   logic              start;
   logic              valid_in;
   logic              inverse;
   logic [ADDR_W-1:0] twiddle_addr;
   logic              addr_valid;
   logic              conj;
   logic              frame_done;
   logic              busy;
   logic              protocol_err;
   modport master (output start, valid_in, inverse,
                   input twiddle_addr, addr_valid, conj, frame_done, busy, protocol_err);
   modport slave  (input start, valid_in, inverse,
                   output twiddle_addr, addr_valid, conj, frame_done, busy, protocol_err);
endinterface

// File: rtl/twiddle_addr_gen.sv
// twiddle_addr_gen: per-sample twiddle ROM address generator for one FFT stage
module twiddle_addr_gen #(
   parameter int NFFT       = 64,
   parameter int SPAN_LOG2  = 6,
   parameter bit MIRROR_INV = 1
) (
   input logic             clk,
   input logic             rst,
   twiddle_addr_gen_if.slave bus
);
   localparam int ADDR_W = $clog2(NFFT);
   localparam int SHIFT  = ADDR_W - SPAN_LOG2;
   localparam logic [ADDR_W-1:0] MASK = ADDR_W'((1 << SPAN_LOG2) - 1);
   localparam logic [ADDR_W-1:0] HALF = ADDR_W'((1 << SPAN_LOG2) / 2);
   localparam logic [ADDR_W-1:0] LAST = ADDR_W'(NFFT - 1);
   typedef enum logic {IDLE, RUN} state_t;
   state_t            state_q;
   logic [ADDR_W-1:0] cnt_q, addr_q, n_d, j_d, base_d, addr_d;
   logic              inv_q, valid_q, conj_q, done_q, err_q;
   logic              acc_d, last_d, inv_d, conj_d;
   // index of the sample accepted this cycle and its twiddle address
   always_comb begin
      acc_d  = bus.valid_in && (state_q == RUN || bus.start);
      n_d    = state_q == IDLE ? '0 : cnt_q;
      inv_d  = state_q == IDLE ? bus.inverse : inv_q;
      last_d = n_d == LAST;
      j_d    = n_d & MASK;
      base_d = j_d < HALF ? '0 : (j_d - HALF) << SHIFT;
      addr_d = (inv_d && MIRROR_INV) ? ADDR_W'('0 - base_d) : base_d;
      conj_d = inv_d && !MIRROR_INV;
   end
   // frame FSM with registered address outputs
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         inv_q   <= 1'b0;
         addr_q  <= '0;
         valid_q <= 1'b0;
         conj_q  <= 1'b0;
         done_q  <= 1'b0;
         err_q   <= 1'b0;
      end else begin
         valid_q <= acc_d;
         done_q  <= acc_d && last_d;
         if (acc_d) begin
            addr_q  <= addr_d;
            conj_q  <= conj_d;
            inv_q   <= inv_d;
            state_q <= last_d ? IDLE : RUN;
            cnt_q   <= last_d ? '0 : n_d + 1'b1;
            if (state_q == RUN && bus.start) err_q <= 1'b1;
         end
      end
   end
   assign bus.twiddle_addr = addr_q;
   assign bus.addr_valid   = valid_q;
   assign bus.conj         = conj_q;
   assign bus.frame_done   = done_q;
   assign bus.busy         = state_q == RUN;
   assign bus.protocol_err = err_q;
endmodule

// File: tb/tb_twiddle_addr_gen.sv
// tb_twiddle_addr_gen: three stage configurations checked against an arithmetic model
module tb_twiddle_addr_gen;
   logic clk = 0, rst = 1;
   always #5 clk = ~clk;
   twiddle_addr_gen_if #(.ADDR_W(6)) i0 ();
   twiddle_addr_gen_if #(.ADDR_W(6)) i1 ();
   twiddle_addr_gen_if #(.ADDR_W(6)) i2 ();
   twiddle_addr_gen #(.NFFT(64), .SPAN_LOG2(6), .MIRROR_INV(1)) d0 (.clk(clk), .rst(rst), .bus(i0));
   twiddle_addr_gen #(.NFFT(64), .SPAN_LOG2(4), .MIRROR_INV(1)) d1 (.clk(clk), .rst(rst), .bus(i1));
   twiddle_addr_gen #(.NFFT(64), .SPAN_LOG2(4), .MIRROR_INV(0)) d2 (.clk(clk), .rst(rst), .bus(i2));
   logic [5:0] g_addr [3];
   logic       g_valid [3], g_conj [3], g_done [3], g_busy [3], g_err [3];
   assign g_addr  = '{i0.twiddle_addr, i1.twiddle_addr, i2.twiddle_addr};
   assign g_valid = '{i0.addr_valid, i1.addr_valid, i2.addr_valid};
   assign g_conj  = '{i0.conj, i1.conj, i2.conj};
   assign g_done  = '{i0.frame_done, i1.frame_done, i2.frame_done};
   assign g_busy  = '{i0.busy, i1.busy, i2.busy};
   assign g_err   = '{i0.protocol_err, i1.protocol_err, i2.protocol_err};
   int spans [3] = '{6, 4, 4};
   bit mirs  [3] = '{1, 1, 0};
   int errors = 0, checks = 0;
   bit m_run, m_inv, m_perr, e_valid, e_done;
   int m_idx;
   int e_addr [3];
   bit e_conj [3];
   function automatic int ref_addr(int n, int span, bit mir, bit inv);
      int m = 1 << span;
      int j = n % m;
      int base = j < m / 2 ? 0 : (j - m / 2) * (64 >> span);
      return (inv && mir) ? (64 - base) % 64 : base;
   endfunction
   task automatic chk(string tag, logic [31:0] got, logic [31:0] exp);
      checks++;
      assert (got === exp) else begin
         errors++;
         $error("FAIL %s got=%0d exp=%0d", tag, got, exp);
      end
   endtask
   task automatic chk_all();
      for (int d = 0; d < 3; d++) begin
         chk($sformatf("addr%0d", d), 32'(g_addr[d]), 32'(e_addr[d]));
         chk($sformatf("valid%0d", d), 32'(g_valid[d]), 32'(e_valid));
         chk($sformatf("done%0d", d), 32'(g_done[d]), 32'(e_done));
         chk($sformatf("busy%0d", d), 32'(g_busy[d]), 32'(m_run));
         chk($sformatf("perr%0d", d), 32'(g_err[d]), 32'(m_perr));
         if (e_valid || rst) chk($sformatf("conj%0d", d), 32'(g_conj[d]), 32'(e_conj[d]));
      end
   endtask
   task automatic model_reset();
      m_run = 0; m_inv = 0; m_perr = 0; m_idx = 0; e_valid = 0; e_done = 0;
      for (int d = 0; d < 3; d++) begin e_addr[d] = 0; e_conj[d] = 0; end
   endtask
   task automatic drive(bit st, bit v, bit inv);
      i0.start = st; i1.start = st; i2.start = st;
      i0.valid_in = v; i1.valid_in = v; i2.valid_in = v;
      i0.inverse = inv; i1.inverse = inv; i2.inverse = inv;
   endtask
   task automatic step(bit st, bit v, bit inv);
      int n;
      drive(st, v, inv);
      @(posedge clk);
      e_valid = v && (m_run || st);
      e_done = 0;
      if (e_valid) begin
         if (m_run && st) m_perr = 1;
         if (!m_run) begin m_inv = inv; n = 0; end else n = m_idx;
         for (int d = 0; d < 3; d++) begin
            e_addr[d] = ref_addr(n, spans[d], mirs[d], m_inv);
            e_conj[d] = m_inv && !mirs[d];
         end
         e_done = n == 63;
         m_run = n != 63;
         m_idx = n == 63 ? 0 : n + 1;
      end
      #1 chk_all();
   endtask
   task automatic run_frame(bit inv, bit stall, int inject, int limit);
      int k = 0, cyc = 0, vcnt = 0;
      while (k < limit && cyc < 1000) begin
         step(k == 0 || k == inject, stall ? 1'($urandom_range(0, 1)) : 1'b1,
              k == 0 ? inv : 1'($urandom_range(0, 1)));
         if (e_valid) k++;
         if (i0.addr_valid) vcnt++;
         cyc++;
      end
      chk("accepts", 32'(vcnt), 32'(limit));
   endtask
   initial begin
      drive(0, 0, 0);
      model_reset();
      #1 chk_all();
      repeat (2) @(posedge clk);
      @(negedge clk) rst = 0;
      step(1, 0, 0);
      step(0, 1, 1);
      step(0, 0, 0);
      run_frame(0, 0, -1, 64);
      run_frame(1, 0, -1, 64);
      run_frame(1, 1, -1, 64);
      run_frame(0, 1, 10, 64);
      run_frame(1, 0, -1, 64);
      run_frame(0, 1, -1, 20);
      #3 rst = 1;
      #1 model_reset();
      chk_all();
      @(posedge clk);
      #1 chk_all();
      @(negedge clk) rst = 0;
      step(0, 1, 0);
      step(0, 1, 1);
      step(1, 0, 1);
      run_frame(1, 0, -1, 64);
      step(0, 1, 0);
      run_frame(0, 1, -1, 64);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule

// File: doc/twiddle_addr_gen.md
TWIDDLE_ADDR_GEN -- requirements
Module: twiddle_addr_gen

Interface
REQ-001 Parameter NFFT, default 64: transform length; a power of two from 16 to 1024.
REQ-002 Parameter SPAN_LOG2, default 6: log2 of the butterfly span M for this stage; legal range 1..log2(NFFT).
REQ-003 Parameter MIRROR_INV, default 1: 1 = inverse mode mirrors the address; 0 = inverse mode drives conj instead.
REQ-004 Derived ADDR_W = log2(NFFT); H = M/2; SHIFT = log2(NFFT) - SPAN_LOG2.
REQ-005 clk  input  1  single clock; all state updates on the rising edge.
REQ-006 rst  input  1  asynchronous, active-high reset.
REQ-007 start  input  1  marks the first sample of a frame; qualified by valid_in.
REQ-008 valid_in  input  1  a sample is accepted in each cycle it is high; low = stall.
REQ-009 inverse  input  1  IFFT mode request; sampled only when a frame starts.
REQ-010 twiddle_addr  output  ADDR_W  registered twiddle ROM address.
REQ-011 addr_valid  output  1  twiddle_addr is valid this cycle.
REQ-012 conj  output  1  consumer conjugates the ROM word; only used when MIRROR_INV=0.
REQ-013 frame_done  output  1  one-cycle pulse, coincident with the address for index NFFT-1.
REQ-014 busy  output  1  high while a frame is partially accepted.
REQ-015 protocol_err  output  1  sticky flag; cleared only by rst.

Function
REQ-016 The FSM SHALL have exactly two states: IDLE and RUN; the sample counter cnt is ADDR_W bits wide.
REQ-017 Frame start, in IDLE: start=1 with valid_in=1 accepts index 0, latches inverse into inv_q, sets cnt=1 and moves to RUN.
REQ-018 In IDLE, start=1 with valid_in=0 is ignored, as is valid_in=1 with start=0; addr_valid stays 0.
REQ-019 In RUN: each cycle with valid_in=1 accepts index cnt and increments cnt; valid_in=0 holds cnt and state.
REQ-020 Acceptance of index NFFT-1 SHALL return the FSM to IDLE and set cnt=0.
REQ-021 A start in the very next cycle SHALL be accepted as index 0 of a new frame (zero-gap back-to-back frames).
REQ-022 start=1 with valid_in=1 while in RUN SHALL set protocol_err; the sample is treated as a normal in-frame sample.
REQ-023 Address function, for accepted index n: j = n mod M; base = 0 if j < H, else (j - H) << SHIFT.
REQ-024 Inverse handling: if inv_q=1 and MIRROR_INV=1, the address is (NFFT - base) mod NFFT and conj=0.
REQ-025 Otherwise the address is base, and conj = inv_q AND NOT MIRROR_INV.
REQ-026 Latency: twiddle_addr, conj, addr_valid and frame_done SHALL be registered and appear exactly 1 cycle after the accepting edge.
REQ-027 addr_valid SHALL be 0 in any cycle that follows a non-accepting cycle; twiddle_addr then holds its last value.
REQ-028 busy SHALL be 1 exactly when the state is RUN.
REQ-029 A change on inverse during RUN SHALL have no effect until the next frame start.
REQ-030 All arithmetic is modulo 2^ADDR_W; no intermediate may exceed ADDR_W+1 bits.

Reset
REQ-031 While rst=1, all of the following SHALL hold: state=IDLE, cnt=0, inv_q=0, twiddle_addr=0, addr_valid=0, conj=0, frame_done=0, busy=0, protocol_err=0.
REQ-032 rst asserted mid-frame SHALL abandon the frame; the first frame after release requires a new start.

Verification
REQ-033 NFFT=64, SPAN_LOG2=6, inverse=0, 64 consecutive accepts -> 32 addresses of 0, then 0,1,...,31; frame_done on the 64th address.
REQ-034 NFFT=64, SPAN_LOG2=4 -> each 16-sample block gives 0 x8, then 0,4,8,...,28.
REQ-035 As REQ-034 with inverse=1, MIRROR_INV=1 -> second half of each block reads 0,60,56,...,36; with MIRROR_INV=0 -> unmirrored addresses and conj=1 throughout.
REQ-036 Stall test: valid_in toggles with a random pattern -> the address sequence is identical to the unstalled case, and addr_valid count = 64.
REQ-037 Two frames back to back with zero gap, plus a start injected at index 10 -> second frame's addresses start at index 0, and protocol_err=1 stays set.
REQ-038 rst pulsed at index 20 -> all outputs 0; a new start restarts at index 0, and valid_in without start is ignored.
